// File: rtl/mux_nto1_pipe.sv
// ---------------------------------------------------------------------------
// mux_nto1_pipe
//
// Registered N-to-1 operand selector for the pipelined datapath. One of
// CHANNELS input channels of SIZE bits is copied into a one-entry output
// register. The register has a valid/ready handshake, so downstream stalls
// are absorbed without losing data.
//
// Parameters
//   SIZE      data width of each channel and of data_o (1..64)
//   CHANNELS  number of input channels (2..8)
//   SEL_W     select width, 2**SEL_W >= CHANNELS
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-low reset
//   data_i     flattened channels, channel k at [k*SIZE +: SIZE]
//   select_i   channel select, sampled on accept
//   valid_i    upstream offers a selection this cycle
//   ready_o    block can accept this cycle (combinational, !valid_o || ready_i)
//   flush_i    drop the held output and ignore valid_i this cycle
//   data_o     registered selected data
//   sel_o      registered effective select that produced data_o
//   valid_o    data_o/sel_o hold a valid result
//   ready_i    downstream consumes data_o this cycle when valid_o=1
//   sel_err_o  sticky: an out-of-range select was accepted (reset clears it)
// ---------------------------------------------------------------------------
module mux_nto1_pipe #(
    parameter int unsigned SIZE     = 32,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CHANNELS*SIZE-1:0] data_i,
    input  logic [SEL_W-1:0]         select_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    output logic [SIZE-1:0]          data_o,
    output logic [SEL_W-1:0]         sel_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     sel_err_o
);

    // One extra bit so CHANNELS is representable even when 2**SEL_W == CHANNELS.
    localparam logic [SEL_W:0]   CHANNELS_W = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(CHANNELS - 1);

    logic [SIZE-1:0]  data_q,  data_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             valid_q, valid_d;
    logic             err_q,   err_d;

    logic             accept;
    logic             in_range;
    logic [SEL_W-1:0] eff_sel;
    logic [SIZE-1:0]  picked;

    // Handshake: ready never looks at valid_i, so no valid->ready loop exists.
    always_comb begin
        ready_o = !valid_q || ready_i;
        accept  = valid_i && ready_o && !flush_i;
    end

    // Unused select codes route to the last channel (legacy behaviour).
    always_comb begin
        in_range = ({1'b0, select_i} < CHANNELS_W);
        eff_sel  = in_range ? select_i : LAST_SEL;
    end

    always_comb begin
        picked = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                picked = data_i[k*SIZE +: SIZE];
            end
        end
    end

    // Priority: flush > accept > drain > hold.
    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            data_d  = picked;
            sel_d   = eff_sel;
            valid_d = 1'b1;
            if (!in_range) begin
                err_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        data_o    = data_q;
        sel_o     = sel_q;
        valid_o   = valid_q;
        sel_err_o = err_q;
    end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
module tb_mux_nto1_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- main instance: CHANNELS=3, SIZE=32 ----------------
    logic [31:0] chan [3];
    logic [95:0] data_i;
    logic [1:0]  select_i = '0;
    logic        valid_i  = 1'b0;
    logic        flush_i  = 1'b0;
    logic        ready_i  = 1'b1;
    logic        ready_o, valid_o, sel_err_o;
    logic [31:0] data_o;
    logic [1:0]  sel_o;

    assign data_i = {chan[2], chan[1], chan[0]};

    mux_nto1_pipe #(.SIZE(32), .CHANNELS(3), .SEL_W(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .data_i(data_i), .select_i(select_i),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
        .data_o(data_o), .sel_o(sel_o), .valid_o(valid_o),
        .ready_i(ready_i), .sel_err_o(sel_err_o)
    );

    // ---------------- sweep instance: CHANNELS=8, SIZE=8 ----------------
    logic [63:0] data8;
    logic [2:0]  sel8   = '0;
    logic        valid8 = 1'b0;
    logic        ready_o8, valid_o8, err8;
    logic [7:0]  data_o8;
    logic [2:0]  sel_o8;

    mux_nto1_pipe #(.SIZE(8), .CHANNELS(8), .SEL_W(3)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .data_i(data8), .select_i(sel8),
        .valid_i(valid8), .ready_o(ready_o8), .flush_i(1'b0),
        .data_o(data_o8), .sel_o(sel_o8), .valid_o(valid_o8),
        .ready_i(1'b1), .sel_err_o(err8)
    );

    // ---------------- sweep instance: CHANNELS=5, SIZE=16 ---------------
    logic [79:0] data5;
    logic [2:0]  sel5   = '0;
    logic        valid5 = 1'b0;
    logic        ready_o5, valid_o5, err5;
    logic [15:0] data_o5;
    logic [2:0]  sel_o5;

    mux_nto1_pipe #(.SIZE(16), .CHANNELS(5), .SEL_W(3)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .data_i(data5), .select_i(sel5),
        .valid_i(valid5), .ready_o(ready_o5), .flush_i(1'b0),
        .data_o(data_o5), .sel_o(sel_o5), .valid_o(valid_o5),
        .ready_i(1'b1), .sel_err_o(err5)
    );

    // ---------------- scoreboard for the main instance ------------------
    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
    } exp_t;

    exp_t sb_q[$];
    logic exp_err = 1'b0;

    // Inputs change at posedge+1, so the negedge sees what the next edge samples.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        logic m_ready;
        logic [1:0] eff;
        if (!rst) begin
            sb_q.delete();
            exp_err = 1'b0;
        end else begin
            m_ready = (sb_q.size() == 0) || ready_i;
            n_checks++;
            if (valid_o !== (sb_q.size() != 0)) begin
                n_fail++;
                $display("FAIL sb_valid: valid_o=%b required %b at %0t", valid_o, sb_q.size() != 0, $time);
            end
            n_checks++;
            if (ready_o !== m_ready) begin
                n_fail++;
                $display("FAIL sb_ready: ready_o=%b required %b at %0t", ready_o, m_ready, $time);
            end
            n_checks++;
            if (sel_err_o !== exp_err) begin
                n_fail++;
                $display("FAIL sb_sel_err: sel_err_o=%b required %b at %0t", sel_err_o, exp_err, $time);
            end
            if (flush_i) begin
                if (sb_q.size() != 0) got = sb_q.pop_front();
            end else begin
                if (ready_i && sb_q.size() != 0) begin
                    got = sb_q.pop_front();
                    n_checks++;
                    if (data_o !== got.data || sel_o !== got.sel) begin
                        n_fail++;
                        $display("FAIL sb_data: data_o=%h sel_o=%0d required %h/%0d at %0t",
                                 data_o, sel_o, got.data, got.sel, $time);
                    end
                end
                if (valid_i && m_ready) begin
                    eff = (select_i < 2'd3) ? select_i : 2'd2;
                    e.data = chan[eff];
                    e.sel  = eff;
                    sb_q.push_back(e);
                    if (select_i == 2'd3) exp_err = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_chans();
        chan[0] = 32'hAAAA0000;
        chan[1] = 32'hBBBB0001;
        chan[2] = 32'hCCCC0002;
    endtask

    task automatic test_reset();
        set_default_chans();
        ready_i = 1'b1;
        valid_i = 1'b1; select_i = 2'd3;
        tick();
        valid_i = 1'b0; ready_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_o !== 32'h0 || sel_o !== 2'd0 || valid_o !== 1'b0 ||
            sel_err_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: data=%h sel=%0d valid=%b err=%b ready=%b required 0/0/0/0/1",
                     data_o, sel_o, valid_o, sel_err_o, ready_o);
        end
        ready_i = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] want [3];
        want[0] = 32'hAAAA0000; want[1] = 32'hBBBB0001; want[2] = 32'hCCCC0002;
        ready_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            valid_i = 1'b1; select_i = 2'(s);
            tick();
            n_checks++;
            if (data_o !== want[s] || valid_o !== 1'b1 || sel_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_sel%0d: data=%h valid=%b err=%b required %h/1/0",
                         s, data_o, valid_o, sel_err_o, want[s]);
            end
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        valid_i = 1'b1; select_i = 2'd3; ready_i = 1'b1;
        tick();
        n_checks++;
        if (data_o !== 32'hCCCC0002 || sel_o !== 2'd2 || sel_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL oor: data=%h sel=%0d err=%b required cccc0002/2/1", data_o, sel_o, sel_err_o);
        end
        for (int k = 0; k < 5; k++) begin
            select_i = 2'(k % 3);
            tick();
        end
        valid_i = 1'b0;
        tick();
        n_checks++;
        if (sel_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_sticky: err=%b required 1", sel_err_o);
        end
    endtask

    task automatic test_stall();
        rst = 1'b0; tick(); rst = 1'b1;
        ready_i = 1'b1; valid_i = 1'b1; select_i = 2'd1;
        tick();
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chan[0] = $urandom; chan[1] = $urandom; chan[2] = $urandom;
            select_i = 2'($urandom_range(0, 3));
            #1;
            n_checks++;
            if (ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ready%0d: ready_o=%b required 0", k, ready_o);
            end
            tick();
            n_checks++;
            if (data_o !== 32'hBBBB0001 || valid_o !== 1'b1 || sel_o !== 2'd1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: data=%h sel=%0d valid=%b required bbbb0001/1/1",
                         k, data_o, sel_o, valid_o);
            end
        end
        set_default_chans();
        ready_i = 1'b1; select_i = 2'd0;
        tick();
        n_checks++;
        if (data_o !== 32'hAAAA0000 || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: data=%h valid=%b required aaaa0000/1", data_o, valid_o);
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        ready_i = 1'b1; valid_i = 1'b1; select_i = 2'd2;
        tick();
        ready_i = 1'b0; valid_i = 1'b0;
        tick();
        flush_i = 1'b1; valid_i = 1'b1; select_i = 2'd0;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || data_o !== 32'hCCCC0002) begin
            n_fail++;
            $display("FAIL flush: valid=%b data=%h required 0/cccc0002", valid_o, data_o);
        end
        ready_i = 1'b1; valid_i = 1'b1; select_i = 2'd1;
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 32'hBBBB0001) begin
            n_fail++;
            $display("FAIL post_flush: valid=%b data=%h required 1/bbbb0001", valid_o, data_o);
        end
        valid_i = 1'b0;
        tick();
    endtask

    // Random mix of valid/ready/flush/select; the scoreboard checks every transfer.
    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            chan[0] = $urandom; chan[1] = $urandom; chan[2] = $urandom;
            valid_i  = ($urandom_range(0, 3) != 0);
            ready_i  = ($urandom_range(0, 2) != 0);
            flush_i  = ($urandom_range(0, 9) == 0);
            select_i = 2'($urandom_range(0, 3));
            tick();
        end
        valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: valid=%b required 0", valid_o);
        end
    endtask

    task automatic test_param_sweep();
        logic [7:0]  want8;
        logic [15:0] want5;
        for (int k = 0; k < 8; k++) data8[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 5; k++) data5[k*16 +: 16] = 16'h0100 + 16'(k);
        for (int k = 0; k < 8; k++) begin
            valid8 = 1'b1; sel8 = 3'(k);
            tick();
            want8 = 8'h10 + 8'(k);
            n_checks++;
            if (data_o8 !== want8 || sel_o8 !== 3'(k) || valid_o8 !== 1'b1 || err8 !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep8_sel%0d: data=%h sel=%0d valid=%b err=%b required %h/%0d/1/0",
                         k, data_o8, sel_o8, valid_o8, err8, want8, k);
            end
        end
        valid8 = 1'b0;
        valid5 = 1'b1; sel5 = 3'd3;
        tick();
        n_checks++;
        if (data_o5 !== 16'h0103 || err5 !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep5_inrange: data=%h err=%b required 0103/0", data_o5, err5);
        end
        sel5 = 3'd6;
        tick();
        valid5 = 1'b0;
        want5 = 16'h0104;
        n_checks++;
        if (data_o5 !== want5 || sel_o5 !== 3'd4 || err5 !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep5_oor: data=%h sel=%0d err=%b required %h/4/1", data_o5, sel_o5, err5, want5);
        end
        tick();
        n_checks++;
        if (err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep8_err: err=%b required 0", err8);
        end
    endtask

    initial begin
        set_default_chans();
        data8 = '0;
        data5 = '0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        test_reset();
        test_basic();
        test_out_of_range();
        test_stall();
        test_flush();
        test_back_to_back();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
